// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx, uart_tx and uart_rx_fifo.
//   uart_byte_t  : one UART data byte
//   CLK_FREQ_HZ  : system clock frequency
//   BAUD         : line rate
//   CLK_PER_BIT  : system clocks per UART bit
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned BAUD        = 115_200;
    localparam int unsigned CLK_PER_BIT = CLK_FREQ_HZ / BAUD;

endpackage

// File: rtl/uart_rise_detect.sv
// Rising-edge detector that turns the uart_rx bb_ready level into a one-cycle strobe.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   i_level  in   level input (bb_ready)
//   o_rise   out  high for one cycle when i_level goes 0 -> 1
// The delayed copy resets to 1, so a level that is already high when reset
// releases is treated as old and never produces a strobe.
module uart_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_d;

    // Level delayed by one clock; reset to 1 to suppress a strobe at reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= 1'b1;
        end else begin
            r_level_d <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO placed after uart_rx. Each rising edge of rx_byte_ready writes one byte;
// bytes are presented first-word-fall-through on a valid/ready stream. A byte that
// arrives while the FIFO is full (and no read happens that cycle) is dropped and
// flagged on the sticky overflow output.
// Parameters: DEPTH (power of two, >= 2), WIDTH (data bits).
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_byte         received byte, sampled on the write strobe
//   rx_byte_ready   uart_rx ready level
//   out_data        head-of-FIFO byte (combinational from storage)
//   out_valid       FIFO not empty
//   out_ready       consumer accepts out_data this cycle
//   count           bytes stored, 0..DEPTH
//   full            count == DEPTH
//   overflow        sticky drop flag
//   clear_overflow  clears overflow (a simultaneous drop wins)
//   drop_count      saturating dropped-byte counter, only with UART_RX_FIFO_DROP_CNT_EN
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           rx_byte,
    input  logic                       rx_byte_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clear_overflow
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_overflow;

    logic w_wr_stb;
    logic w_empty;
    logic w_full;
    logic w_rd_fire;
    logic w_drop;
    logic w_wr_en;

    uart_rise_detect u_rise (
        .clk     (clk),
        .rst     (rst),
        .i_level (rx_byte_ready),
        .o_rise  (w_wr_stb)
    );

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_fire = ~w_empty & out_ready;
    // A read in the same cycle frees the slot, so a full FIFO only drops without one.
    assign w_drop    = w_wr_stb & w_full & ~w_rd_fire;
    assign w_wr_en   = w_wr_stb & ~w_drop;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= rx_byte;
        end
    end

    // Read/write pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Sticky overflow; a new drop takes priority over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] r_drop_count;

    // Saturating count of dropped bytes; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign out_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid = ~w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = w_full;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_byte_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clear_overflow;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_byte        (rx_byte),
        .rx_byte_ready  (rx_byte_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef UART_RX_FIFO_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    // Reference model: stored bytes, sticky flag, drop counter, previous ready level.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       m_prev;
    logic       m_ovf;
    int         m_drops;
    int         n_cmp = 0;
    int         n_err = 0;

    // One clock: apply inputs, record any accepted DUT byte, advance the model.
    task automatic cycle(input logic rdy, input logic [7:0] b, input logic ordy, input logic clr);
        logic rd, wr, was_full, dropped;
        rx_byte_ready  = rdy;
        rx_byte        = b;
        out_ready      = ordy;
        clear_overflow = clr;
        #1;
        if (out_valid && out_ready) got_q.push_back(out_data);
        was_full = (m_q.size() == DEPTH);
        rd       = (m_q.size() != 0) && ordy;
        wr       = rdy && !m_prev;
        dropped  = wr && was_full && !rd;
        if (rd) exp_q.push_back(m_q.pop_front());
        if (wr && !dropped) m_q.push_back(b);
        if (dropped) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        m_prev = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] b, input logic ordy);
        cycle(1'b1, b, ordy, 1'b0);
        cycle(1'b0, b, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input logic hold_rdy);
        rst = 1'b1; rx_byte_ready = hold_rdy; out_ready = 1'b0; clear_overflow = 1'b0; rx_byte = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete(); exp_q.delete(); got_q.delete();
        m_prev = 1'b1; m_ovf = 1'b0; m_drops = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h77, 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if ({full, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {full, overflow}); end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        got_q.delete(); exp_q.delete();
        cycle(1'b1, 8'h61, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid: got %b want 1", out_valid); end
        cycle(1'b1, 8'h61, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        pulse(8'h62, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL basic_n: got %0d want 2", got_q.size()); end
        else begin
            n_cmp++; if (got_q[0] !== 8'h61) begin n_err++; $display("FAIL basic_b0: got %h want 61", got_q[0]); end
            n_cmp++; if (got_q[1] !== 8'h62) begin n_err++; $display("FAIL basic_b1: got %h want 62", got_q[1]); end
        end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL basic_count: got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < DEPTH; i++) pulse(8'(i), 1'b0);
        n_cmp++; if ({full, count} !== {1'b1, 5'd16}) begin n_err++; $display("FAIL fill: got full=%b count=%0d want 1/16", full, count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL no_ovf_yet: got %b want 0", overflow); end
        pulse(8'hAA, 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", count); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL head_stable: got %h want 00", out_data); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        drain();
        n_cmp++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL drain_n: got %0d want 16", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            n_cmp++; if (got_q[i] !== 8'(i)) begin n_err++; $display("FAIL drain_order[%0d]: got %h want %h", i, got_q[i], 8'(i)); end
        end
    endtask

    task automatic test_full_simul();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < DEPTH; i++) pulse(8'($urandom), 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL simul_count: got %0d want 16", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf: got %b want 0", overflow); end
        drain();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL simul_n: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL simul_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'h55) begin n_err++; $display("FAIL simul_last: got %h want 55", got_q.size() ? got_q[got_q.size()-1] : 8'hxx); end
    endtask

    task automatic test_hold_and_clear();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 50; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL hold_one: got %0d want 1", count); end
        for (int i = 1; i < DEPTH; i++) pulse(8'(i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL set_wins: got %b want 1", overflow); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL clear_after: got %b want %b", overflow, m_ovf); end
        drain();
        n_cmp++; if (got_q.size() == 0 || got_q[0] !== 8'h30) begin n_err++; $display("FAIL hold_byte: got %h want 30", got_q.size() ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_random_wrap();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
            n_cmp++; if (count !== 5'(m_q.size()) || full !== (m_q.size() == DEPTH) || overflow !== m_ovf) begin
                n_err++; $display("FAIL rand_state[%0d]: got count=%0d full=%b ovf=%b want %0d/%b/%b", i, count, full, overflow, m_q.size(), m_q.size() == DEPTH, m_ovf);
            end
        end
        drain();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_n: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

`ifdef UART_RX_FIFO_DROP_CNT_EN
    task automatic test_drop_cnt();
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) pulse(8'(i), 1'b0);
        for (int i = 0; i < 3; i++) pulse(8'hBB, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (drop_count !== 16'(m_drops) || drop_count !== 16'd3) begin n_err++; $display("FAIL drop_count: got %0d want 3", drop_count); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_full_simul();
        test_hold_and_clear();
        test_random_wrap();
`ifdef UART_RX_FIFO_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
